// File: rtl/instr_fetch_if.sv
// Instruction-memory read port between the fetch stage (master) and a synchronous IMEM (slave).
// Read data appears on rdata the cycle after rd_en is sampled high.
interface instr_fetch_if #(
  parameter int IMEM_AW = 10
);
  logic               rd_en;
  logic [IMEM_AW-1:0] addr;
  logic [31:0]        rdata;

  modport master (output rd_en, output addr, input rdata);
  modport slave  (input rd_en, input addr, output rdata);
endinterface

// File: rtl/instr_fetch.sv
// Fetch stage of the KGP miniRISC pipeline: PC, synchronous IMEM read, IF/ID register with
// a one-entry skid buffer for downstream stall, branch/jump redirect and halt.
module instr_fetch #(
  parameter int                ADDR_W   = 32,
  parameter int                IMEM_AW  = 10,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  instr_fetch_if.master     imem,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt,
  output logic [31:0]       instr,
  output logic [5:0]        opcode,
  output logic [5:0]        func,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              instr_valid,
  output logic              halted
);

  localparam logic [ADDR_W-1:0] FOUR       = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] fetch_pc;
  logic              pend;
  logic [ADDR_W-1:0] pend_pc;
  logic              skid_valid;
  logic [31:0]       skid_instr;
  logic [ADDR_W-1:0] skid_pc;
  logic              run;
  logic              issue;

  // State register
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; HALT is only left through rst.
  // NOTE: default assignment first so no path through always_comb can infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    state_nxt = RUN;
      RUN:     if (halt) state_nxt = HALT;
      HALT:    state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: a read is issued only while running and nothing downstream blocks it.
  always_comb begin
    run        = (state == RUN);
    issue      = run & ~stall & ~redirect & ~halt;
    imem.rd_en = issue;
    imem.addr  = fetch_pc[IMEM_AW+1:2];
  end

  // PC, in-flight tracking, skid buffer and IF/ID register
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      pend        <= 1'b0;
      pend_pc     <= '0;
      skid_valid  <= 1'b0;
      skid_instr  <= '0;
      skid_pc     <= '0;
      instr       <= '0;
      pc          <= '0;
      pc_plus4    <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      pend <= issue;
      if (issue) begin
        fetch_pc <= fetch_pc + FOUR;
        pend_pc  <= fetch_pc;
      end

      if (run && halt) begin
        pend        <= 1'b0;
        skid_valid  <= 1'b0;
        instr_valid <= 1'b0;
        halted      <= 1'b1;
      end else if (run && redirect) begin
        // The read issued last cycle returns this cycle and is simply dropped.
        fetch_pc    <= redirect_pc & ALIGN_MASK;
        pend        <= 1'b0;
        skid_valid  <= 1'b0;
        instr_valid <= 1'b0;
      end else if (stall) begin
        // Only the read issued in the last non-stall cycle can land here, so one entry suffices.
        if (pend) begin
          skid_instr <= imem.rdata;
          skid_pc    <= pend_pc;
          skid_valid <= 1'b1;
        end
      end else if (skid_valid) begin
        instr       <= skid_instr;
        pc          <= skid_pc;
        pc_plus4    <= skid_pc + FOUR;
        instr_valid <= 1'b1;
        skid_valid  <= 1'b0;
      end else if (pend) begin
        instr       <= imem.rdata;
        pc          <= pend_pc;
        pc_plus4    <= pend_pc + FOUR;
        instr_valid <= 1'b1;
      end else begin
        instr_valid <= 1'b0;
      end
    end
  end

  assign opcode = instr[31:26];
  assign func   = instr[5:0];

endmodule
